// File: rtl/wb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_sram_ctrl
//
// Wishbone classic slave that bridges the management-SoC bus to a 1 KB
// dual-port SRAM macro (256 words x 32 bits). Port A of the macro is read-only
// and serves every read. Port B is read/write with a byte mask and serves every
// write. Port B is never read, so its data output is not an input here.
//
// The slave decodes a 1 KB window at BASE_ADDR. The word address is
// wbs_adr_i[9:2]; byte-lane bits [1:0] are ignored. A request outside the
// window is acknowledged immediately with zero data and touches no SRAM port.
//
// Every output is driven from a flop. The macro registers its inputs on the
// clock edge, so each chip select is driven low for exactly one cycle. Read
// data appears on sram_dout_a in the cycle after the address edge.
//
// Optional feature (macro WB_SRAM_PIPE_EN):
//   When defined, an extra RD_PIPE state follows RD_WAIT. The macro output is
//   first captured into an internal register and is copied to wbs_dat_o one
//   cycle later. This gives the macro clock-to-out a full cycle. Read latency
//   becomes 4 cycles instead of 3. Writes and misses are unaffected.
//
// Parameters:
//   BASE_ADDR    window base address; bits [9:0] must be zero
//
// Ports:
//   wb_clk_i     sole clock; also clocks both SRAM ports
//   wb_rstn_i    synchronous active-low reset
//   wbs_stb_i    Wishbone strobe
//   wbs_cyc_i    Wishbone cycle
//   wbs_we_i     Wishbone write enable
//   wbs_sel_i    byte selects
//   wbs_adr_i    byte address
//   wbs_dat_i    write data
//   wbs_ack_o    one-cycle acknowledge
//   wbs_dat_o    registered read data
//   sram_csb_a   read port chip select (active-low)
//   sram_addr_a  read port word address
//   sram_dout_a  read port data
//   sram_csb_b   read/write port chip select (active-low)
//   sram_web_b   read/write port write enable (active-low)
//   sram_mask_b  read/write port byte write mask
//   sram_addr_b  read/write port word address
//   sram_din_b   read/write port write data
//   busy_o       high whenever the controller is not idle
// -----------------------------------------------------------------------------
module wb_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        sram_csb_a,
  output logic [7:0]  sram_addr_a,
  input  logic [31:0] sram_dout_a,
  output logic        sram_csb_b,
  output logic        sram_web_b,
  output logic [3:0]  sram_mask_b,
  output logic [7:0]  sram_addr_b,
  output logic [31:0] sram_din_b,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_PIPE = 3'd4,
    S_ACK     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        csb_a_q, csb_a_d;
  logic [7:0]  addr_a_q, addr_a_d;
  logic        csb_b_q, csb_b_d;
  logic        web_b_q, web_b_d;
  logic [3:0]  mask_b_q, mask_b_d;
  logic [7:0]  addr_b_q, addr_b_d;
  logic [31:0] din_b_q, din_b_d;

`ifdef WB_SRAM_PIPE_EN
  // Holds the macro output for one cycle before it reaches wbs_dat_o.
  logic [31:0] rd_pipe_q, rd_pipe_d;
`endif

  logic hit;
  logic req;
  logic unused_adr;

  assign hit = (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  // The ack term prevents a new request from being sampled while the current
  // acknowledge is still on the bus.
  assign req = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign unused_adr = ^wbs_adr_i[1:0];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = dat_q;
    csb_a_d  = 1'b1;
    addr_a_d = addr_a_q;
    csb_b_d  = 1'b1;
    web_b_d  = 1'b1;
    mask_b_d = mask_b_q;
    addr_b_d = addr_b_q;
    din_b_d  = din_b_q;
`ifdef WB_SRAM_PIPE_EN
    rd_pipe_d = rd_pipe_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit && wbs_we_i) begin
            state_d  = S_WR;
            csb_b_d  = 1'b0;
            web_b_d  = 1'b0;
            mask_b_d = wbs_sel_i;
            addr_b_d = wbs_adr_i[9:2];
            din_b_d  = wbs_dat_i;
          end else if (hit) begin
            state_d  = S_RD;
            csb_a_d  = 1'b0;
            addr_a_d = wbs_adr_i[9:2];
          end else begin
            // Out-of-window access: acknowledge at once with zero data.
            state_d = S_ACK;
            ack_d   = 1'b1;
            dat_d   = 32'h0;
          end
        end
      end

      S_WR: begin
        // The macro captures the write at this edge whatever cyc does. Only
        // the acknowledge is dropped when the master has abandoned the cycle.
        if (wbs_cyc_i) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD: begin
        state_d = wbs_cyc_i ? S_RD_WAIT : S_IDLE;
      end

      S_RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
`ifdef WB_SRAM_PIPE_EN
          rd_pipe_d = sram_dout_a;
          state_d   = S_RD_PIPE;
`else
          dat_d   = sram_dout_a;
          state_d = S_ACK;
          ack_d   = 1'b1;
`endif
        end
      end

      S_RD_PIPE: begin
`ifdef WB_SRAM_PIPE_EN
        dat_d   = rd_pipe_q;
        state_d = S_ACK;
        ack_d   = 1'b1;
`else
        state_d = S_IDLE;
`endif
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy_o is registered, so it follows the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      busy_q   <= 1'b0;
      csb_a_q  <= 1'b1;
      addr_a_q <= 8'h0;
      csb_b_q  <= 1'b1;
      web_b_q  <= 1'b1;
      mask_b_q <= 4'h0;
      addr_b_q <= 8'h0;
      din_b_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      busy_q   <= busy_d;
      csb_a_q  <= csb_a_d;
      addr_a_q <= addr_a_d;
      csb_b_q  <= csb_b_d;
      web_b_q  <= web_b_d;
      mask_b_q <= mask_b_d;
      addr_b_q <= addr_b_d;
      din_b_q  <= din_b_d;
    end
  end

`ifdef WB_SRAM_PIPE_EN
  // This is a pure data stage. It is always overwritten before it is used,
  // so it has no reset.
  always_ff @(posedge wb_clk_i) begin
    rd_pipe_q <= rd_pipe_d;
  end
`endif

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign busy_o      = busy_q;
  assign sram_csb_a  = csb_a_q;
  assign sram_addr_a = addr_a_q;
  assign sram_csb_b  = csb_b_q;
  assign sram_web_b  = web_b_q;
  assign sram_mask_b = mask_b_q;
  assign sram_addr_b = addr_b_q;
  assign sram_din_b  = din_b_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_ctrl
//
// Directed bench for wb_sram_ctrl. It contains a behavioural model of the
// dual-port SRAM macro: inputs are registered on the clock edge, and port B
// writes honour the byte mask. Directed transactions are checked against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_wb_sram_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_SRAM_PIPE_EN
  localparam int RD_LAT = 4;
`else
  localparam int RD_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        csb_a;
  logic [7:0]  addr_a;
  logic [31:0] dout_a;
  logic        csb_b;
  logic        web_b;
  logic [3:0]  mask_b;
  logic [7:0]  addr_b;
  logic [31:0] din_b;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic        mon_en = 1'b0;
  logic        prev_a_low = 1'b0;
  logic        prev_b_low = 1'b0;

  // Port values captured one cycle after the request edge.
  logic        cap_csb_a, cap_csb_b, cap_web_b;
  logic [7:0]  cap_addr_a, cap_addr_b;
  logic [3:0]  cap_mask_b;
  logic [31:0] cap_din_b;

  int          lat;
  logic [31:0] rd;

  wb_sram_ctrl #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .sram_csb_a  (csb_a),
    .sram_addr_a (addr_a),
    .sram_dout_a (dout_a),
    .sram_csb_b  (csb_b),
    .sram_web_b  (web_b),
    .sram_mask_b (mask_b),
    .sram_addr_b (addr_b),
    .sram_din_b  (din_b),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // SRAM macro model: inputs are registered; read data follows the address edge.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!csb_b && !web_b) begin
      for (int i = 0; i < 4; i++)
        if (mask_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
    if (!csb_a) dout_a <= mem[addr_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Chip selects are never low together; each low pulse lasts one cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("csb_excl", 32'(csb_a | csb_b), 32'd1);
      chk("csb_a_1cyc", 32'(!csb_a && prev_a_low), 32'd0);
      chk("csb_b_1cyc", 32'(!csb_b && prev_b_low), 32'd0);
    end
    prev_a_low = !csb_a;
    prev_b_low = !csb_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int n, output logic [31:0] data);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        cap_csb_a = csb_a; cap_csb_b = csb_b; cap_web_b = web_b;
        cap_addr_a = addr_a; cap_addr_b = addr_b;
        cap_mask_b = mask_b; cap_din_b = din_b;
      end
    end while (!ack && n < 12);
    if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
    data = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    step();
    chk("ack_pulse", 32'(ack), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},    32'(ack),    32'd0);
    chk({tag, "_dat"},    rdat,        32'h0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_csb_a"},  32'(csb_a),  32'd1);
    chk({tag, "_csb_b"},  32'(csb_b),  32'd1);
    chk({tag, "_web_b"},  32'(web_b),  32'd1);
    chk({tag, "_mask_b"}, 32'(mask_b), 32'd0);
    chk({tag, "_addr_a"}, 32'(addr_a), 32'd0);
    chk({tag, "_addr_b"}, 32'(addr_b), 32'd0);
    chk({tag, "_din_b"},  din_b,       32'h0);
  endtask

  initial begin
    // Reset held for two cycles.
    rstn = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    rstn = 1'b1;
    step();
    mon_en = 1'b1;

    // Full-word write to the top word, then read it back.
    wb_xfer(1'b1, BASE + 32'h3FC, 32'hDEADBEEF, 4'hF, lat, rd);
    chk("wr_lat",    32'(lat),        32'd2);
    chk("wr_csb_b",  32'(cap_csb_b),  32'd0);
    chk("wr_web_b",  32'(cap_web_b),  32'd0);
    chk("wr_addr_b", 32'(cap_addr_b), 32'hFF);
    chk("wr_mask_b", 32'(cap_mask_b), 32'hF);
    chk("wr_din_b",  cap_din_b,       32'hDEADBEEF);
    wb_xfer(1'b0, BASE + 32'h3FC, 32'h0, 4'hF, lat, rd);
    chk("rd_lat",    32'(lat),        32'(RD_LAT));
    chk("rd_csb_a",  32'(cap_csb_a),  32'd0);
    chk("rd_addr_a", 32'(cap_addr_a), 32'hFF);
    chk("rd_data",   rd,              32'hDEADBEEF);

    // Byte-masked write over a preloaded word.
    wb_xfer(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, lat, rd);
    wb_xfer(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd);
    chk("bm_mask_b", 32'(cap_mask_b), 32'h5);
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, lat, rd);
    chk("bm_data",   rd,              32'h11BB33DD);

    // A write with no byte selects still completes but changes nothing.
    wb_xfer(1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0, lat, rd);
    chk("sel0_lat",  32'(lat),        32'd2);
    chk("sel0_mask", 32'(cap_mask_b), 32'h0);
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, lat, rd);
    chk("sel0_data", rd,              32'h11BB33DD);

    // Out-of-window read.
    wb_xfer(1'b0, BASE + 32'h400, 32'h0, 4'hF, lat, rd);
    chk("miss_lat",   32'(lat),       32'd1);
    chk("miss_data",  rd,             32'h0);
    chk("miss_csb_a", 32'(cap_csb_a), 32'd1);
    chk("miss_csb_b", 32'(cap_csb_b), 32'd1);

    // Back-to-back write, read, write, read with no extra idle cycles.
    wb_xfer(1'b1, BASE + 32'h10, 32'h0BADF00D, 4'hF, lat, rd);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, rd);
    chk("b2b_rd1", rd, 32'h0BADF00D);
    wb_xfer(1'b1, BASE + 32'h14, 32'h12345678, 4'hF, lat, rd);
    chk("b2b_wr_addr", 32'(cap_addr_b), 32'h05);
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, lat, rd);
    chk("b2b_rd2", rd, 32'h12345678);
    // Byte-lane address bits are ignored.
    wb_xfer(1'b0, BASE + 32'h13, 32'h0, 4'hF, lat, rd);
    chk("lane_addr_a", 32'(cap_addr_a), 32'h04);
    chk("lane_data",   rd,              32'h0BADF00D);

    // Abort: cyc dropped in RD_WAIT.
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h14;
    step();
    step();
    chk("abort_busy_wait", 32'(busy), 32'd1);
    stb = 1'b0; cyc = 1'b0;
    step();
    chk("abort_ack",   32'(ack),   32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_csb_a", 32'(csb_a), 32'd1);
    chk("abort_dat",   rdat,       32'h0BADF00D);
    step();
    chk("abort_ack2",  32'(ack),   32'd0);

    // Reset asserted in RD_WAIT.
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h14;
    step();
    step();
    rstn = 1'b0;
    step();
    chk_reset_vals("midrst");
    rstn = 1'b1;
    stb = 1'b0; cyc = 1'b0;
    step();
    chk("midrst_ack", 32'(ack), 32'd0);

    // The controller works normally after the mid-transaction reset.
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, lat, rd);
    chk("post_rst_lat",  32'(lat), 32'(RD_LAT));
    chk("post_rst_data", rd,       32'h12345678);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
